// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    localparam int DEF_GAP_CYCLES    = 27;
    localparam int DEF_MAX_MSG_BYTES = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake from the two requesters plus the transmitter start/busy link.
interface uart_tx_arbiter_if;
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       s1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport slave (
        input  s0_valid, s0_data, s0_last,
        input  s1_valid, s1_data, s1_last,
        input  tx_busy,
        output s0_ready, s1_ready, tx_start, tx_data
    );

    modport master (
        output s0_valid, s0_data, s0_last,
        output s1_valid, s1_data, s1_last,
        output tx_busy,
        input  s0_ready, s1_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Two-input round-robin pick; on a tie the requester that did not own last wins.
module rr_arbiter_2
    import uart_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01:   gnt = GNT_0;
            2'b10:   gnt = GNT_1;
            2'b11:   gnt = last_owner ? GNT_0 : GNT_1;
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants whole messages to one of two requesters and feeds bytes into a UART
// transmitter with a start/busy handshake and an idle gap between messages.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus,
    output logic [1:0]        grant,
    output logic              msg_done,
    output logic              msg_trunc
);

    localparam int CW = $clog2(MAX_MSG_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t          state_reg;
    logic [1:0]      grant_reg;
    logic            last_owner_reg;
    logic [CW-1:0]   byte_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic [7:0]      tx_data_reg;
    logic            last_flag_reg;
    logic            blank_reg;
    logic            msg_done_reg;
    logic            msg_trunc_reg;

    logic [1:0] valid_vec;
    logic [1:0] ready_vec;
    logic [1:0] pick;
    logic       accept;
    logic [7:0] data_sel;
    logic       last_sel;

    assign valid_vec = {bus.s1_valid, bus.s0_valid};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_vec[gi] = (state_reg == LOAD) && grant_reg[gi] && valid_vec[gi] && !bus.tx_busy;
    end

    assign accept   = |ready_vec;
    assign data_sel = grant_reg[1] ? bus.s1_data : bus.s0_data;
    assign last_sel = grant_reg[1] ? bus.s1_last : bus.s0_last;

    rr_arbiter_2 u_rr (
        .req        (valid_vec),
        .last_owner (last_owner_reg),
        .gnt        (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= GNT_NONE;
            last_owner_reg <= 1'b1;
            byte_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            tx_data_reg    <= 8'h00;
            last_flag_reg  <= 1'b0;
            blank_reg      <= 1'b0;
            msg_done_reg   <= 1'b0;
            msg_trunc_reg  <= 1'b0;
        end else begin
            msg_done_reg  <= 1'b0;
            msg_trunc_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|valid_vec) begin
                        grant_reg <= pick;
                        state_reg <= LOAD;
                    end
                end
                // A requester that pauses mid-message keeps the grant.
                LOAD: begin
                    if (accept) begin
                        tx_data_reg   <= data_sel;
                        last_flag_reg <= last_sel;
                        byte_cnt_reg  <= byte_cnt_reg + CW'(1);
                        state_reg     <= START;
                    end
                end
                START: begin
                    blank_reg <= 1'b1;
                    state_reg <= WAIT;
                end
                // First WAIT cycle is blanked: the transmitter may not have raised busy yet.
                WAIT: begin
                    blank_reg <= 1'b0;
                    if (!blank_reg && !bus.tx_busy) begin
                        if (last_flag_reg || (byte_cnt_reg == CW'(MAX_MSG_BYTES))) begin
                            msg_done_reg   <= last_flag_reg;
                            msg_trunc_reg  <= !last_flag_reg;
                            grant_reg      <= GNT_NONE;
                            last_owner_reg <= grant_reg[1];
                            byte_cnt_reg   <= '0;
                            if (GAP_CYCLES == 0) begin
                                state_reg <= IDLE;
                            end else begin
                                gap_cnt_reg <= GW'(GAP_CYCLES);
                                state_reg   <= GAP;
                            end
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                GAP: begin
                    gap_cnt_reg <= gap_cnt_reg - GW'(1);
                    if (gap_cnt_reg <= GW'(1)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.s0_ready = ready_vec[0];
    assign bus.s1_ready = ready_vec[1];
    assign bus.tx_start = (state_reg == START);
    assign bus.tx_data  = tx_data_reg;
    assign grant        = grant_reg;
    assign msg_done     = msg_done_reg;
    assign msg_trunc    = msg_trunc_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 10-cycle transmitter busy model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int GAP      = 27;
    localparam int MAXB     = 4;
    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       msg_done;
    logic       msg_trunc;
    logic       force_busy = 1'b0;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.GAP_CYCLES(GAP), .MAX_MSG_BYTES(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant     (grant),
        .msg_done  (msg_done),
        .msg_trunc (msg_trunc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_start) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    assign bus.tx_busy = force_busy || (busy_cnt != 0);

    // Event logs captured on the falling edge
    int         st_cyc[$];
    logic [7:0] st_data[$];
    logic [1:0] st_gnt[$];
    int         done_cyc[$];
    int         trunc_cyc[$];
    int         g1_cyc[$];
    int         bad_gnt = 0;
    logic [1:0] prev_gnt = 2'b00;

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            st_cyc.push_back(cyc);
            st_data.push_back(bus.tx_data);
            st_gnt.push_back(grant);
            $display("tx_start: data=%h grant=%b cycle=%0d", bus.tx_data, grant, cyc);
        end
        if (msg_done === 1'b1) done_cyc.push_back(cyc);
        if (msg_trunc === 1'b1) trunc_cyc.push_back(cyc);
        if (grant === 2'b10 && prev_gnt !== 2'b10) g1_cyc.push_back(cyc);
        if (grant === 2'b11) bad_gnt <= bad_gnt + 1;
        prev_gnt <= grant;
    end

    task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
        if (p == 0) begin
            bus.s0_valid = v; bus.s0_data = d; bus.s0_last = l;
        end else begin
            bus.s1_valid = v; bus.s1_data = d; bus.s1_last = l;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.s0_ready : bus.s1_ready;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input int p, input logic [7:0] d, input logic l);
        int t = 0;
        drive(p, 1'b1, d, l);
        #1;
        while (rdy(p) !== 1'b1 && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        if (rdy(p) !== 1'b1) begin
            checks++; fails++;
            $display("FAIL send_timeout port%0d: ready=%b after %0d cycles, required 1", p, rdy(p), t);
        end
        @(negedge clk);
        drive(p, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_msg(input int p, input logic [7:0] b0, input int n, input logic last_end);
        for (int i = 0; i < n; i++)
            send_byte(p, b0 + 8'(i), last_end && (i == n - 1));
    endtask

    task automatic wait_events(input int n);
        int t = 0;
        while ((done_cyc.size() + trunc_cyc.size()) < n && t < 3000) begin
            @(negedge clk); #2; t++;
        end
        if ((done_cyc.size() + trunc_cyc.size()) < n) begin
            checks++; fails++;
            $display("FAIL msg_event_timeout: got %0d events, required %0d", done_cyc.size() + trunc_cyc.size(), n);
        end
    endtask

    task automatic settle();
        repeat (GAP + 4) @(negedge clk);
    endtask

    task automatic clear_logs();
        st_cyc.delete(); st_data.delete(); st_gnt.delete();
        done_cyc.delete(); trunc_cyc.delete(); g1_cyc.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.s0_ready !== 1'b0) begin fails++; $display("FAIL reset_s0_ready: got %b, expected 0", bus.s0_ready); end
        checks++; if (bus.s1_ready !== 1'b0) begin fails++; $display("FAIL reset_s1_ready: got %b, expected 0", bus.s1_ready); end
        checks++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b, expected 0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h, expected 00", bus.tx_data); end
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b, expected 00", grant); end
        checks++; if (msg_done !== 1'b0 || msg_trunc !== 1'b0) begin fails++; $display("FAIL reset_pulses: got done=%b trunc=%b, expected 0 0", msg_done, msg_trunc); end
    endtask

    task automatic test_single();
        int t0;
        @(negedge clk);
        clear_logs();
        t0 = cyc;
        send_msg(0, 8'h41, 2, 1'b1);
        wait_events(1);
        settle();
        checks++; if (st_data.size() != 2) begin fails++; $display("FAIL single_count: got %0d starts, expected 2", st_data.size()); end
        checks++; if (st_data[0] !== 8'h41 || st_data[1] !== 8'h42) begin fails++; $display("FAIL single_data: got %h %h, expected 41 42", st_data[0], st_data[1]); end
        checks++; if (st_gnt[0] !== 2'b01 || st_gnt[1] !== 2'b01) begin fails++; $display("FAIL single_grant: got %b %b, expected 01 01", st_gnt[0], st_gnt[1]); end
        checks++; if (st_cyc[0] - t0 != 2) begin fails++; $display("FAIL single_latency: got %0d, expected 2", st_cyc[0] - t0); end
        checks++; if (st_cyc[1] - st_cyc[0] != 13) begin fails++; $display("FAIL single_spacing: got %0d, expected 13", st_cyc[1] - st_cyc[0]); end
        checks++; if (done_cyc.size() != 1 || trunc_cyc.size() != 0) begin fails++; $display("FAIL single_done: got done=%0d trunc=%0d, expected 1 0", done_cyc.size(), trunc_cyc.size()); end
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL single_release: got %b, expected 00", grant); end
    endtask

    task automatic test_contention();
        apply_reset();
        clear_logs();
        fork
            send_msg(0, 8'hA0, 2, 1'b1);
            send_msg(1, 8'hB0, 1, 1'b1);
        join
        wait_events(2);
        settle();
        fork
            send_msg(0, 8'hA8, 1, 1'b1);
            send_msg(1, 8'hB8, 1, 1'b1);
        join
        wait_events(4);
        settle();
        checks++; if (st_data.size() != 5) begin fails++; $display("FAIL cont_count: got %0d starts, expected 5", st_data.size()); end
        checks++; if (st_data[0] !== 8'hA0 || st_gnt[0] !== 2'b01) begin fails++; $display("FAIL cont_first: got %h/%b, expected a0/01", st_data[0], st_gnt[0]); end
        checks++; if (st_data[2] !== 8'hB0 || st_gnt[2] !== 2'b10) begin fails++; $display("FAIL cont_second: got %h/%b, expected b0/10", st_data[2], st_gnt[2]); end
        checks++; if (g1_cyc.size() < 1 || g1_cyc[0] - done_cyc[0] != GAP + 1) begin fails++; $display("FAIL cont_gap: got %0d, expected %0d", g1_cyc[0] - done_cyc[0], GAP + 1); end
        checks++; if (st_data[3] !== 8'hA8 || st_data[4] !== 8'hB8) begin fails++; $display("FAIL cont_tie2: got %h %h, expected a8 b8", st_data[3], st_data[4]); end
    endtask

    task automatic test_truncation();
        apply_reset();
        clear_logs();
        send_msg(1, 8'h60, 6, 1'b0);
        repeat (15) @(negedge clk);
        #2;
        checks++; if (st_data.size() != 6) begin fails++; $display("FAIL trunc_count: got %0d starts, expected 6", st_data.size()); end
        checks++; if (trunc_cyc.size() != 1 || done_cyc.size() != 0) begin fails++; $display("FAIL trunc_pulses: got trunc=%0d done=%0d, expected 1 0", trunc_cyc.size(), done_cyc.size()); end
        checks++; if (trunc_cyc[0] - st_cyc[3] != 12) begin fails++; $display("FAIL trunc_timing: got %0d, expected 12", trunc_cyc[0] - st_cyc[3]); end
        checks++; if (st_cyc[4] - st_cyc[3] != GAP + 14) begin fails++; $display("FAIL trunc_regrant: got %0d, expected %0d", st_cyc[4] - st_cyc[3], GAP + 14); end
        checks++; if (st_data[4] !== 8'h64 || st_data[5] !== 8'h65 || st_gnt[4] !== 2'b10) begin fails++; $display("FAIL trunc_rest: got %h %h/%b, expected 64 65/10", st_data[4], st_data[5], st_gnt[4]); end
        checks++; if (g1_cyc.size() != 2) begin fails++; $display("FAIL trunc_new_grant: got %0d grants, expected 2", g1_cyc.size()); end
        apply_reset();
    endtask

    task automatic test_valid_gap();
        int bad = 0;
        @(negedge clk);
        clear_logs();
        fork
            begin
                send_byte(0, 8'hC0, 1'b0);
                repeat (20) begin
                    @(negedge clk); #2;
                    if (grant !== 2'b01 || bus.s1_ready !== 1'b0) bad++;
                end
                send_byte(0, 8'hC1, 1'b1);
            end
            begin
                @(negedge clk);
                send_msg(1, 8'hD0, 1, 1'b1);
            end
        join
        wait_events(2);
        settle();
        checks++; if (bad != 0) begin fails++; $display("FAIL vgap_hold: got %0d bad cycles, expected 0", bad); end
        checks++; if (st_data[0] !== 8'hC0 || st_data[1] !== 8'hC1 || st_data[2] !== 8'hD0) begin fails++; $display("FAIL vgap_order: got %h %h %h, expected c0 c1 d0", st_data[0], st_data[1], st_data[2]); end
        checks++; if (st_gnt[1] !== 2'b01 || st_gnt[2] !== 2'b10) begin fails++; $display("FAIL vgap_grant: got %b %b, expected 01 10", st_gnt[1], st_gnt[2]); end
    endtask

    task automatic test_busy_respect();
        int bad = 0;
        int t = 0;
        int rel = 0;
        logic rdy_rel = 1'b0;
        @(negedge clk);
        clear_logs();
        force_busy = 1'b1;
        fork
            send_msg(0, 8'hE0, 1, 1'b1);
            begin
                while (grant !== 2'b01 && t < 100) begin @(negedge clk); #2; t++; end
                if (grant !== 2'b01) begin
                    checks++; fails++;
                    $display("FAIL busy_grant_timeout: got %b, expected 01", grant);
                end
                repeat (8) begin
                    @(negedge clk); #2;
                    if (bus.s0_ready !== 1'b0 || bus.tx_start !== 1'b0) bad++;
                end
                @(negedge clk);
                force_busy = 1'b0;
                rel = cyc;
                #1;
                rdy_rel = bus.s0_ready;
            end
        join
        wait_events(1);
        settle();
        checks++; if (bad != 0) begin fails++; $display("FAIL busy_hold: got %0d bad cycles, expected 0", bad); end
        checks++; if (rdy_rel !== 1'b1) begin fails++; $display("FAIL busy_accept: got ready=%b, expected 1", rdy_rel); end
        checks++; if (st_cyc[0] != rel + 1 || st_data[0] !== 8'hE0) begin fails++; $display("FAIL busy_start: got cyc %0d data %h, expected %0d e0", st_cyc[0], st_data[0], rel + 1); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        @(negedge clk);
        clear_logs();
        send_msg(0, 8'hF0, 1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (grant !== 2'b00 || bus.tx_data !== 8'h00) begin fails++; $display("FAIL rmid_state: got grant=%b data=%h, expected 00 00", grant, bus.tx_data); end
        checks++; if (bus.tx_start !== 1'b0 || bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin fails++; $display("FAIL rmid_ctrl: got start=%b r0=%b r1=%b, expected 0 0 0", bus.tx_start, bus.s0_ready, bus.s1_ready); end
        checks++; if (msg_done !== 1'b0 || msg_trunc !== 1'b0) begin fails++; $display("FAIL rmid_pulses: got %b %b, expected 0 0", msg_done, msg_trunc); end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #2;
        checks++; if (st_data.size() != 1 || done_cyc.size() != 0) begin fails++; $display("FAIL rmid_quiet: got starts=%0d done=%0d, expected 1 0", st_data.size(), done_cyc.size()); end
        @(negedge clk);
        send_msg(0, 8'h5A, 1, 1'b1);
        while (st_data.size() < 2 && t < 100) begin @(negedge clk); #2; t++; end
        checks++; if (st_data.size() != 2 || st_data[1] !== 8'h5A || st_gnt[1] !== 2'b01) begin fails++; $display("FAIL rmid_resume: got %0d starts data %h grant %b, expected 2 5a 01", st_data.size(), st_data[1], st_gnt[1]); end
        wait_events(1);
        checks++; if (bad_gnt != 0) begin fails++; $display("FAIL grant_onehot: got %0d cycles of 11, expected 0", bad_gnt); end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single();
        test_contention();
        test_truncation();
        test_valid_gap();
        test_busy_respect();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
